// File: rtl/puf_pkg.sv
// Shared types and default widths for the ring-oscillator PUF sequencer.
package puf_pkg;

    localparam int DEF_SEL_W     = 5;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_WINDOW_W  = 8;
    localparam int DEF_RESP_BITS = 8;
    localparam int SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        COMPARE,
        DONE
    } puf_state_e;

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter for the RUN window; expired marks the last enabled cycle.
module puf_window_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired = en && (cnt_q == W'(1));

endmodule

// File: rtl/puf_challenge_sequencer.sv
// PUF challenge sequencer: walks RESP_BITS oscillator pairs and builds the response.
// Define PUF_MAJORITY_EN to measure every bit three times and take the majority.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int SEL_W     = DEF_SEL_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WINDOW_W  = DEF_WINDOW_W,
    parameter int RESP_BITS = DEF_RESP_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SEL_W-1:0]     base_sel,
    input  logic [WINDOW_W-1:0]  window,
    input  logic [CNT_W-1:0]     count_a,
    input  logic [CNT_W-1:0]     count_b,
    output logic                 osc_en,
    output logic                 cnt_clr,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic                 ovf
);

    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int STL_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    puf_state_e           state_q, state_d;
    logic [SEL_W-1:0]     base_q, base_d;
    logic [WINDOW_W-1:0]  win_q, win_d;
    logic [IDX_W-1:0]     i_q, i_d;
    logic [STL_W-1:0]     stl_q, stl_d;
    logic [RESP_BITS-1:0] response_q, response_d;
    logic                 ovf_q, ovf_d;
    logic [SEL_W-1:0]     sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic                 osc_en_q, osc_en_d, cnt_clr_q, cnt_clr_d;
    logic                 busy_q, busy_d, done_q, done_d;
`ifdef PUF_MAJORITY_EN
    logic [1:0]           rep_q, rep_d, votes_q, votes_d;
`endif
    logic                 res, bit_val, bit_last_pass, win_expired;

    puf_window_timer #(.W(WINDOW_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q == CLEAR),
        .load_val (win_q),
        .en       (state_q == RUN),
        .expired  (win_expired)
    );

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        win_d         = win_q;
        i_d           = i_q;
        stl_d         = stl_q;
        response_d    = response_q;
        ovf_d         = ovf_q;
        sel_a_d       = sel_a_q;
        sel_b_d       = sel_b_q;
`ifdef PUF_MAJORITY_EN
        rep_d         = rep_q;
        votes_d       = votes_q;
`endif
        res           = (count_a > count_b);
        bit_val       = 1'b0;
        bit_last_pass = 1'b0;

        unique case (state_q)
            IDLE: if (start) begin
                state_d    = CLEAR;
                base_d     = base_sel;
                win_d      = (window == '0) ? WINDOW_W'(1) : window;
                i_d        = '0;
                response_d = '0;
                ovf_d      = 1'b0;
`ifdef PUF_MAJORITY_EN
                rep_d      = '0;
                votes_d    = '0;
`endif
            end
            CLEAR: state_d = RUN;
            RUN: if (win_expired) begin
                state_d = SETTLE;
                stl_d   = '0;
            end
            SETTLE: begin
                if (stl_q == STL_W'(SETTLE_CYCLES - 1)) state_d = COMPARE;
                else                                    stl_d   = stl_q + STL_W'(1);
            end
            COMPARE: begin
                if (count_a == '1 || count_b == '1) ovf_d = 1'b1;
`ifdef PUF_MAJORITY_EN
                bit_last_pass = (rep_q == 2'd2);
                bit_val       = ((votes_q + {1'b0, res}) >= 2'd2);
                votes_d       = bit_last_pass ? 2'd0 : votes_q + {1'b0, res};
                rep_d         = bit_last_pass ? 2'd0 : rep_q + 2'd1;
`else
                bit_last_pass = 1'b1;
                bit_val       = res;
`endif
                if (!bit_last_pass) begin
                    state_d = CLEAR;
                end else begin
                    response_d[i_q] = bit_val;
                    if (int'(i_q) == RESP_BITS - 1) begin
                        state_d = DONE;
                    end else begin
                        i_d     = i_q + IDX_W'(1);
                        state_d = CLEAR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Selectors move only on entry to CLEAR so they stay put through COMPARE.
        if (state_d == CLEAR) begin
            sel_a_d = base_d + SEL_W'({i_d, 1'b0});
            sel_b_d = sel_a_d + SEL_W'(1);
        end

        osc_en_d  = (state_d == RUN);
        cnt_clr_d = (state_d == CLEAR);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            win_q      <= '0;
            i_q        <= '0;
            stl_q      <= '0;
            response_q <= '0;
            ovf_q      <= 1'b0;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            osc_en_q   <= 1'b0;
            cnt_clr_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PUF_MAJORITY_EN
            rep_q      <= '0;
            votes_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            win_q      <= win_d;
            i_q        <= i_d;
            stl_q      <= stl_d;
            response_q <= response_d;
            ovf_q      <= ovf_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            osc_en_q   <= osc_en_d;
            cnt_clr_q  <= cnt_clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef PUF_MAJORITY_EN
            rep_q      <= rep_d;
            votes_q    <= votes_d;
`endif
        end
    end

    assign osc_en   = osc_en_q;
    assign cnt_clr  = cnt_clr_q;
    assign sel_a    = sel_a_q;
    assign sel_b    = sel_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign response = response_q;
    assign ovf      = ovf_q;

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Sequencer for the ring-oscillator PUF datapath. On a start request it walks through RESP_BITS oscillator pairs selected from a base challenge. For each pair it clears the edge counters, enables the oscillators for a programmable window, lets the counters settle, and compares the two counts into one response bit. It sits between the chip I/O (challenge, start, response) and the oscillator bank, its 32:1 selectors and its 8-bit counters.

## Interface
Parameters:
- SEL_W, 5, oscillator select width; pair indices wrap modulo 2^SEL_W
- CNT_W, 8, edge-counter width
- WINDOW_W, 8, measurement-window register width
- RESP_BITS, 8, response bits per run

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  run request, sampled only in IDLE
- base_sel  in  SEL_W  challenge, latched on accepted start
- window  in  WINDOW_W  RUN length in clk cycles, latched on accepted start
- count_a, count_b  in  CNT_W  counter values, already synchronised to clk by the datapath
- osc_en  out  1  oscillator enable
- cnt_clr  out  1  counter clear, synchronous, one cycle
- sel_a, sel_b  out  SEL_W  selector controls for counters A and B
- busy  out  1  high from the accepted start until DONE is left
- done  out  1  one-cycle pulse when the run completes
- response  out  RESP_BITS  result, held until the next accepted start
- ovf  out  1  sticky for the run; set if either count equals all-ones at COMPARE

## Operation
- States:
  - IDLE: waits for start.
  - CLEAR: 1 cycle; cnt_clr=1, osc_en=0.
  - RUN: win cycles; osc_en=1.
  - SETTLE: 2 cycles; osc_en=0.
  - COMPARE: 1 cycle.
  - DONE: 1 cycle; done=1.
- Transitions:
  - IDLE→CLEAR on start.
  - CLEAR→RUN, RUN→SETTLE, SETTLE→COMPARE.
  - COMPARE→CLEAR if more bits remain, else →DONE.
  - DONE→IDLE.
- Accepted start:
  - latches base_sel and window; a window of 0 is latched as 1.
  - clears response, ovf and the bit index i.
- Pair selection for bit i: sel_a = (base_sel + 2i) mod 2^SEL_W, sel_b = (sel_a + 1) mod 2^SEL_W. Both are held stable from CLEAR through COMPARE.
- COMPARE writes response[i] = (count_a > count_b). A tie gives 0.
- Comparison is unsigned at CNT_W; no arithmetic widening.
- start while busy is ignored; it is not queued.
- rst_n low at any clock edge, including mid-run, gives IDLE with all outputs 0 on the following cycle.

## Timing
- Reset values: osc_en, cnt_clr, busy, done, ovf, sel_a, sel_b and response are all 0.
- Cycle numbering: the accepted start edge is cycle 0. For W = latched window:
  - CLEAR of bit k is at cycle k(W+4)+1.
  - RUN of bit k covers cycles k(W+4)+2 .. k(W+4)+W+1.
  - COMPARE of bit k is at cycle (k+1)(W+4).
  - done is high at cycle RESP_BITS·(W+4)+1.
- busy rises at cycle 1 and falls the cycle after done.
- response[i] is visible the cycle after its COMPARE.
- osc_en is never high in the same cycle as cnt_clr.

## Configuration
- PUF_MAJORITY_EN defined: each bit is measured three times. This is three CLEAR/RUN/SETTLE/COMPARE passes on the same pair. response[i] is the majority of the three compare results. A 2-bit repeat counter is added. done moves to cycle 3·RESP_BITS·(W+4)+1.
- PUF_MAJORITY_EN undefined: one pass per bit, as described above.

## Structure
- Shared package puf_pkg holds:
  - the state enum: IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE
  - SETTLE_CYCLES=2
  - the default widths (SEL_W, CNT_W, WINDOW_W, RESP_BITS)
- One sub-module, puf_window_timer: a loadable down-counter that asserts expiry on its last RUN cycle. The FSM, pair generator and response register stay in the top.

## Test plan
- Basic run:
  - Stimulus: base_sel=3, window=10, count_a=50 and count_b=40 for every bit.
  - Required: response=8'hFF, done at cycle 113, busy cycles 1–113, ovf=0.
- Pair wrap:
  - Stimulus: base_sel=30.
  - Required: bit0 selects 30/31, bit1 selects 0/1, bit7 selects 12/13.
- Tie and ovf:
  - Stimulus: count_a=count_b=20 on bit 2; count_a=8'hFF on bit 5.
  - Required: response[2]=0, ovf=1 after bit 5's COMPARE and held until the next start.
- Window 0 and start during a run:
  - Stimulus: window=0; start pulsed again at cycle 20.
  - Required: each RUN lasts 1 cycle, done at cycle 41, and the second start has no effect.
- Mid-run reset:
  - Stimulus: rst_n low at cycle 30, then a start after release.
  - Required: all outputs 0 on the next cycle; the new start runs normally.
- Majority (PUF_MAJORITY_EN defined):
  - Stimulus: per-pass results 1,0,1 on bit 0 and 0,0,1 on bit 1, with window=10.
  - Required: response[0]=1, response[1]=0, done at cycle 337.
